chroma_timing_ctl: RTL
======================

CHROMA_TIMING_CTL -- requirements
Module: chroma_timing_ctl

Interface
REQ-001 Parameter H_TOTAL, 448: clocks-enabled per line; hcnt range 0..H_TOTAL-1.
REQ-002 Parameter H_BLANK_START, 320: first blanked hcnt.
REQ-003 Parameter H_BLANK_END, 415: last blanked hcnt, inclusive.
REQ-004 Parameter H_SYNC_START, 336: first hcnt with hsync_n low.
REQ-005 Parameter H_SYNC_LEN, 32: hsync_n low width, in ce cycles.
REQ-006 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port ce, input, 1: pixel enable; counters and outputs advance only when ce=1.
REQ-009 Port ntsc_req, input, 1: requested standard; 0=PAL, 1=NTSC.
REQ-010 Port chroma_req, input, 1: requested colour enable.
REQ-011 Port hcnt, output, 9: horizontal position.
REQ-012 Port vcnt, output, 9: line number.
REQ-013 Port hsync_n, output, 1: active-low line sync to the chroma generator hsync input.
REQ-014 Port csync_n, output, 1: active-low composite sync.
REQ-015 Port blank, output, 1: high during horizontal blank or vertical-sync lines.
REQ-016 Port cg_enable, output, 1: chroma generator colour enable.
REQ-017 Port cg_pnsel, output, 1: chroma generator standard select; 0=PAL, 1=NTSC.
REQ-018 Port line_start, output, 1: one-clk pulse on line wrap.
REQ-019 Port frame_start, output, 1: one-clk pulse on frame wrap.

Function
REQ-020 When ce=1, hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
REQ-021 V_TOTAL is 312 if cg_pnsel=0, else 262; vcnt wraps from V_TOTAL-1 to 0 together with an hcnt wrap.
REQ-022 The vertical FSM shall have states V_ACTIVE, V_FRONT, V_SYNC and V_BACK, each advanced only on hcnt wrap.
REQ-023 PAL line ranges: V_ACTIVE 0..239, V_FRONT 240..247, V_SYNC 248..251, V_BACK 252..311.
REQ-024 NTSC line ranges: V_ACTIVE 0..239, V_FRONT 240..241, V_SYNC 242..245, V_BACK 246..261.
REQ-025 V_BACK shall go to V_ACTIVE on frame wrap; any other FSM/vcnt mismatch shall resolve to V_ACTIVE at the next frame wrap.
REQ-026 Outputs are registered from next-state counter values, so every output always corresponds to the current hcnt/vcnt; no additional latency.
REQ-027 hsync_n=0 for H_SYNC_START <= hcnt < H_SYNC_START+H_SYNC_LEN, else 1, on every line.
REQ-028 csync_n=hsync_n outside V_SYNC; in V_SYNC csync_n = NOT hsync_n.
REQ-029 blank=1 when H_BLANK_START <= hcnt <= H_BLANK_END, or the state is V_SYNC.
REQ-030 cg_enable = chroma_q AND NOT blank, where chroma_q samples chroma_req at each hcnt wrap.
REQ-031 cg_pnsel samples ntsc_req only at frame wrap; the wrapping edge itself uses the sampled value, so a request on that edge applies to the new frame.
REQ-032 line_start=1 for exactly the clk following an hcnt wrap edge; 0 otherwise, including while ce=0.
REQ-033 frame_start=1 for exactly the clk following a vcnt wrap edge, coincident with line_start.
REQ-034 With ce=0, all counters, FSM state and level outputs shall hold.

Reset
REQ-035 rst=1 shall immediately force: hcnt=0, vcnt=0, FSM=V_ACTIVE, cg_pnsel=0, chroma_q=0, hsync_n=1, csync_n=1, blank=0, cg_enable=0, line_start=0, frame_start=0.
REQ-036 Reset asserted mid-line or mid-frame shall abandon the line/frame; counting resumes from (0,0) on the first ce after release.

Verification
REQ-037 Reset, then ce=1 continuously, PAL -> hsync_n low for hcnt 336..367; blank high for hcnt 320..415; frame_start every 448*312 = 139776 clks.
REQ-038 ntsc_req set at vcnt=100 -> cg_pnsel flips only at the next frame wrap; following frame period is 448*262 = 117376 clks; V_SYNC on lines 242..245.
REQ-039 PAL line 249 -> csync_n=1 for hcnt 336..367 and 0 elsewhere; blank=1 for the whole line.
REQ-040 chroma_req=1 toggled mid-line at hcnt=100 -> cg_enable stays 0 until the next line; then 1 for hcnt 0..319 and 416..447, 0 for 320..415.
REQ-041 ce toggling 1-of-4 -> counts advance per ce only; line_start/frame_start remain one clk wide.
REQ-042 rst pulsed at vcnt=150, hcnt=200 -> all outputs at their reset values within the same cycle; after release, hcnt=1 after the first ce.

Source files
------------

// File: rtl/chroma_timing_ctl.sv
// Raster timing controller for a chroma generator: horizontal/vertical counters,
// PAL/NTSC vertical sequencing, sync/blank generation and colour enable.
module chroma_timing_ctl #(
  parameter int H_TOTAL       = 448,
  parameter int H_BLANK_START = 320,
  parameter int H_BLANK_END   = 415,
  parameter int H_SYNC_START  = 336,
  parameter int H_SYNC_LEN    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       ntsc_req,
  input  logic       chroma_req,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hsync_n,
  output logic       csync_n,
  output logic       blank,
  output logic       cg_enable,
  output logic       cg_pnsel,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [1:0] V_ACTIVE = 2'd0;
  localparam logic [1:0] V_FRONT  = 2'd1;
  localparam logic [1:0] V_SYNC   = 2'd2;
  localparam logic [1:0] V_BACK   = 2'd3;

  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] HB_FIRST = 9'(H_BLANK_START);
  localparam logic [8:0] HB_LAST  = 9'(H_BLANK_END);
  localparam logic [8:0] HS_FIRST = 9'(H_SYNC_START);
  localparam logic [8:0] HS_END   = 9'(H_SYNC_START + H_SYNC_LEN);

  localparam logic [8:0] FRONT_LINE     = 9'd240;
  localparam logic [8:0] PAL_SYNC_LINE  = 9'd248;
  localparam logic [8:0] PAL_BACK_LINE  = 9'd252;
  localparam logic [8:0] PAL_LAST_LINE  = 9'd311;
  localparam logic [8:0] NTSC_SYNC_LINE = 9'd242;
  localparam logic [8:0] NTSC_BACK_LINE = 9'd246;
  localparam logic [8:0] NTSC_LAST_LINE = 9'd261;

  logic [1:0] vstate, vstate_nxt;
  logic [8:0] hcnt_nxt, vcnt_nxt;
  logic [8:0] v_last, v_sync_line, v_back_line;
  logic       chroma_q, chroma_q_nxt, pnsel_nxt;
  logic       h_wrap, f_wrap;
  logic       hsync_nxt, vsync_nxt, csync_nxt, blank_nxt, cg_enable_nxt;

  // Standard in force for the frame currently being scanned.
  always_comb begin
    v_last      = cg_pnsel ? NTSC_LAST_LINE : PAL_LAST_LINE;
    v_sync_line = cg_pnsel ? NTSC_SYNC_LINE : PAL_SYNC_LINE;
    v_back_line = cg_pnsel ? NTSC_BACK_LINE : PAL_BACK_LINE;
  end

  always_comb begin
    h_wrap       = ce && (hcnt == H_LAST);
    f_wrap       = h_wrap && (vcnt == v_last);
    hcnt_nxt     = hcnt;
    vcnt_nxt     = vcnt;
    vstate_nxt   = vstate;
    chroma_q_nxt = chroma_q;
    pnsel_nxt    = cg_pnsel;

    if (ce) hcnt_nxt = h_wrap ? 9'd0 : hcnt + 9'd1;

    if (h_wrap) begin
      chroma_q_nxt = chroma_req;
      vcnt_nxt     = f_wrap ? 9'd0 : vcnt + 9'd1;
    end

    // Frame wrap always restarts in V_ACTIVE, which also clears any stray state.
    if (f_wrap) begin
      pnsel_nxt  = ntsc_req;
      vstate_nxt = V_ACTIVE;
    end else if (h_wrap) begin
      case (vstate)
        V_ACTIVE: if (vcnt_nxt == FRONT_LINE)  vstate_nxt = V_FRONT;
        V_FRONT:  if (vcnt_nxt == v_sync_line) vstate_nxt = V_SYNC;
        V_SYNC:   if (vcnt_nxt == v_back_line) vstate_nxt = V_BACK;
        default:  vstate_nxt = vstate;
      endcase
    end
  end

  always_comb begin
    hsync_nxt     = !((hcnt_nxt >= HS_FIRST) && (hcnt_nxt < HS_END));
    vsync_nxt     = (vstate_nxt == V_SYNC);
    csync_nxt     = vsync_nxt ? !hsync_nxt : hsync_nxt;
    blank_nxt     = ((hcnt_nxt >= HB_FIRST) && (hcnt_nxt <= HB_LAST)) || vsync_nxt;
    cg_enable_nxt = chroma_q_nxt && !blank_nxt;
  end

  // NOTE: outputs are decoded from the *next* counter values and registered with
  // non-blocking assignments, so they line up with hcnt/vcnt without a cycle of lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt        <= 9'd0;
      vcnt        <= 9'd0;
      vstate      <= V_ACTIVE;
      cg_pnsel    <= 1'b0;
      chroma_q    <= 1'b0;
      hsync_n     <= 1'b1;
      csync_n     <= 1'b1;
      blank       <= 1'b0;
      cg_enable   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      vstate      <= vstate_nxt;
      cg_pnsel    <= pnsel_nxt;
      chroma_q    <= chroma_q_nxt;
      hsync_n     <= hsync_nxt;
      csync_n     <= csync_nxt;
      blank       <= blank_nxt;
      cg_enable   <= cg_enable_nxt;
      line_start  <= h_wrap;
      frame_start <= f_wrap;
    end
  end

endmodule
